// File: rtl/vend_pkg.sv
// Shared types and constants for the coin credit vending block.
package vend_pkg;

    localparam int CREDIT_W = 7;

    typedef logic [CREDIT_W-1:0] credit_t;
    // One bit wider than credit, so the overflow test on credit + coin is exact.
    typedef logic [CREDIT_W:0]   sum_t;

    localparam credit_t NICKEL_C  = credit_t'(5);
    localparam credit_t DIME_C    = credit_t'(10);
    localparam credit_t QUARTER_C = credit_t'(25);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } state_e;

    // Result of arbitrating the coin edges seen in one cycle.
    typedef struct packed {
        credit_t value;  // value of the highest coin, 0 if none
        logic    any;    // at least one coin edge
        logic    multi;  // more than one coin edge, so some were dropped
    } coin_pick_t;

    // Highest-value coin wins: quarter > dime > nickel.
    function automatic coin_pick_t pick_coin(input logic n, input logic d, input logic q);
        coin_pick_t p;
        p.any   = n | d | q;
        p.multi = (n & d) | (n & q) | (d & q);
        if (q)      p.value = QUARTER_C;
        else if (d) p.value = DIME_C;
        else if (n) p.value = NICKEL_C;
        else        p.value = '0;
        return p;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Registered rising-edge detector for one debounced level input.
// A level that rises before clock edge k gives a one-cycle pulse in the
// cycle after edge k. Both flops reset to 0, so a level held high through
// reset release yields exactly one pulse.
module edge_detector (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic pulse
);

    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Sample the level, then keep last cycle's sample for comparison.
    always_comb begin
        sync_d = level;
        prev_d = sync_q;
    end

    // Sample and history registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/coin_credit_fsm.sv
// Coin credit vending controller: accumulates nickel/dime/quarter credit,
// dispenses once credit reaches PRICE (returning the excess as change) and
// refunds the credit on a cancel edge.
// Optional feature: define COIN_TIMEOUT_EN to build an inactivity counter
// that auto-refunds after TIMEOUT_CYCLES idle cycles in COLLECT.
module coin_credit_fsm
    import vend_pkg::*;
#(
    parameter int PRICE          = 75,
    parameter int MAX_CREDIT     = 100,
    parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                refund,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                coin_reject
);

    localparam credit_t PRICE_C   = credit_t'(PRICE);
    localparam sum_t    PRICE_S   = sum_t'(PRICE);
    localparam sum_t    MAX_CRD_S = sum_t'(MAX_CREDIT);

    logic nickel_p, dime_p, quarter_p, cancel_p;

    edge_detector u_ed_nickel  (.clk(clk), .reset_n(reset_n), .level(nickel),  .pulse(nickel_p));
    edge_detector u_ed_dime    (.clk(clk), .reset_n(reset_n), .level(dime),    .pulse(dime_p));
    edge_detector u_ed_quarter (.clk(clk), .reset_n(reset_n), .level(quarter), .pulse(quarter_p));
    edge_detector u_ed_cancel  (.clk(clk), .reset_n(reset_n), .level(cancel),  .pulse(cancel_p));

    state_e     state_q, state_d;
    credit_t    credit_q, credit_d;
    coin_pick_t pick;
    sum_t       sum_w;
    logic       fits;
    logic       timeout_hit;
    logic       coin_ok;

    assign pick  = pick_coin(nickel_p, dime_p, quarter_p);
    assign sum_w = {1'b0, credit_q} + {1'b0, pick.value};
    assign fits  = (sum_w <= MAX_CRD_S);

`ifdef COIN_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef logic [TO_W-1:0] cnt_t;

    cnt_t idle_cnt_q, idle_cnt_d;

    // Inactivity count: cleared by any coin/cancel edge or outside COLLECT.
    always_comb begin
        if (state_q != COLLECT || pick.any || cancel_p)
            idle_cnt_d = '0;
        else
            idle_cnt_d = idle_cnt_q + cnt_t'(1);
    end

    // Inactivity counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) idle_cnt_q <= '0;
        else          idle_cnt_q <= idle_cnt_d;
    end

    assign timeout_hit = (state_q == COLLECT) && !pick.any && !cancel_p &&
                         (idle_cnt_q == cnt_t'(TIMEOUT_CYCLES - 1));
`else
    // No counter: credit waits in COLLECT for ever. The comparison is never
    // true for a legal (positive) TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // A coin is credited only from IDLE/COLLECT, when no refund is being
    // taken this cycle and it keeps credit within MAX_CREDIT. A cancel edge
    // in IDLE is ignored, so it does not block a coin there.
    assign coin_ok = pick.any && fits &&
                     ((state_q == IDLE) ||
                      (state_q == COLLECT && !cancel_p && !timeout_hit));

    // State and credit registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
        end
    end

    // Next state: refund beats coins in COLLECT; VEND/REFUND last one cycle.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (state_q == COLLECT && (cancel_p || timeout_hit)) begin
                    state_d = REFUND;
                end else if (coin_ok) begin
                    credit_d = sum_w[CREDIT_W-1:0];
                    state_d  = (sum_w >= PRICE_S) ? VEND : COLLECT;
                end
            end
            VEND, REFUND: begin
                state_d  = IDLE;
                credit_d = '0;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Outputs decoded from the current state; reset clears them at once.
    always_comb begin
        credit        = credit_q;
        dispense      = 1'b0;
        refund        = 1'b0;
        change_amount = '0;
        coin_reject   = pick.multi | (pick.any & ~coin_ok);
        case (state_q)
            VEND: begin
                dispense      = 1'b1;
                change_amount = credit_q - PRICE_C;
            end
            REFUND: begin
                refund        = 1'b1;
                change_amount = credit_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/coin_credit_fsm.md
COIN_CREDIT_FSM -- requirements
Module: coin_credit_fsm

Interface
REQ-001 Parameter PRICE, default 75, item price in cents; a multiple of 5, range 5..MAX_CREDIT.
REQ-002 Parameter MAX_CREDIT, default 100, highest credit the block holds, in cents; a multiple of 5, at most 127.
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000_000, idle cycles before auto-refund; used only under COIN_TIMEOUT_EN.
REQ-004 The block has one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 nickel  input  1  debounced coin-slot level; 5 cents per rising edge.
REQ-008 dime  input  1  debounced coin-slot level; 10 cents per rising edge.
REQ-009 quarter  input  1  debounced coin-slot level; 25 cents per rising edge.
REQ-010 cancel  input  1  debounced refund-button level; acts on its rising edge.
REQ-011 credit  output  7  current accumulated credit in cents.
REQ-012 dispense  output  1  one-cycle pulse that releases the item.
REQ-013 refund  output  1  one-cycle pulse that returns money; amount is on change_amount.
REQ-014 change_amount  output  7  cents to return; valid only while dispense or refund is high, 0 otherwise.
REQ-015 coin_reject  output  1  one-cycle pulse; the coin edge seen this cycle was not credited.

Function
REQ-016 Each level input SHALL pass through a registered rising-edge detector, so a level rising before clock edge k produces an internal edge pulse in the cycle after edge k.
REQ-017 FSM states SHALL be IDLE (credit 0), COLLECT (0 < credit < PRICE), VEND, REFUND.
REQ-018 A coin edge SHALL update credit on the next clock edge, giving 1-cycle latency from the edge pulse to the credit output.
REQ-019 When several coin edges fall in the same cycle, only the highest-value coin SHALL be credited (quarter > dime > nickel), and coin_reject SHALL pulse once for the dropped coins.
REQ-020 A coin whose value would take credit above MAX_CREDIT SHALL NOT be credited, and coin_reject SHALL pulse.
REQ-021 When credit becomes >= PRICE, the FSM SHALL enter VEND for exactly one cycle.
REQ-022 In VEND: dispense = 1, change_amount = credit - PRICE, coin edges rejected with coin_reject; then the FSM goes to IDLE and credit is set to 0.
REQ-023 A cancel edge in COLLECT SHALL enter REFUND for exactly one cycle.
REQ-024 In REFUND: refund = 1, change_amount = credit; then the FSM goes to IDLE and credit is set to 0.
REQ-025 A cancel edge in IDLE SHALL be ignored, with no refund pulse.
REQ-026 When a cancel edge and a coin edge occur in the same cycle, cancel SHALL win: the coin is rejected, and the refund covers the prior credit only.
REQ-027 dispense and refund SHALL never be high in the same cycle.
REQ-028 All credit arithmetic SHALL be unsigned 7-bit, with no wrap-around possible under REQ-002 and REQ-020.

Reset
REQ-029 reset_n low SHALL immediately force state IDLE, credit 0, dispense 0, refund 0, change_amount 0, coin_reject 0, and clear the edge-detector registers.
REQ-030 Edge-detector registers SHALL reset to 0, so an input held high through reset deassertion yields one edge on the first clock after reset.
REQ-031 Reset during VEND or REFUND SHALL abort the pulse, with no dispense or refund on the following cycle.

Configuration
REQ-032 With macro COIN_TIMEOUT_EN defined, an inactivity counter SHALL clear on every coin or cancel edge and count while in COLLECT.
REQ-033 Under COIN_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL enter REFUND exactly as for a cancel edge.
REQ-034 Without COIN_TIMEOUT_EN, no counter SHALL be built, and credit is held in COLLECT indefinitely.

Structure
REQ-035 Package vend_pkg SHALL hold the state enum, the coin values (NICKEL_C = 5, DIME_C = 10, QUARTER_C = 25) and the 7-bit credit width constant.
REQ-036 The rising-edge detector SHALL be a sub-module named edge_detector, instantiated four times.

Verification
REQ-037 Quarter edges x3 with PRICE = 75 -> credit 25, 50, 75 at 1-cycle latency, then one dispense pulse with change_amount 0, then credit 0.
REQ-038 Quarter x2 then dime x3 -> credit reaches 80, then dispense with change_amount 5.
REQ-039 Dime x2 then cancel -> one refund pulse with change_amount 20, then credit 0; a second cancel gives no pulse.
REQ-040 Quarter, nickel and dime edges in the same cycle -> credit +25 and one coin_reject pulse; cancel with a coin at credit 50 -> refund 50 and coin_reject.
REQ-041 Coins to credit 95 with PRICE = 100 and MAX_CREDIT = 100, then quarter -> coin_reject, credit stays 95.
REQ-042 With COIN_TIMEOUT_EN and TIMEOUT_CYCLES = 16, nickel then idle -> refund with change_amount 5 exactly 16 cycles after the credit update; reset asserted mid-COLLECT -> credit 0 immediately.
